enemy_rom_scheduler: RTL and testbench
======================================

# enemy_rom_scheduler

Round-robin read scheduler for the shared enemy sprite ROM. It takes per-enemy read requests from the eight enemy sprite engines and issues the one-hot `rden` that steers the enemy address multiplexer. It then tracks each read through the ROM pipeline and delivers the returned word to the requesting enemy with a one-cycle acknowledge. It sits between the enemy sprite engines and the address-mux/ROM pair, and closes the read loop that the mux opens.

## Interface
Parameters:
- `DATA_W`, 8: ROM word width.
- `ROM_LAT`, 2: number of rising edges from the edge that asserts `rden` to `rom_q` being valid. This is 1 for the mux register plus 1 for the registered ROM. Legal range is ≥1.

Ports:
- `clk`  in  1: system clock. All outputs change on the rising edge only.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  8: per-enemy read request. Level-sensitive; bit i belongs to enemy i.
- `rden`  out  8: one-hot grant to the address mux. Registered; at most one bit is set.
- `rom_q`  in  DATA_W: ROM read data.
- `data_out`  out  8*DATA_W: per-enemy returned word. Slice `[i*DATA_W +: DATA_W]` belongs to enemy i.
- `ack`  out  8: one-cycle pulse when slice i has been updated.
- `busy`  out  1: high while any read is granted or in flight.

## Operation
- Arbitration:
  - Eligible set = `req & ~inflight`.
  - Each edge, if the eligible set is non-zero, grant the first eligible enemy searching upward from `ptr+1` mod 8.
  - On a grant: `rden` is set to that enemy's one-hot bit, its `inflight` bit is set, and `ptr` becomes the granted index.
  - If the eligible set is zero, `rden` is set to 0.
- Throughput: one grant per cycle, with no bubbles between back-to-back grants.
- Tag pipeline: a ROM_LAT+1 stage shift register of one-hot tags, with the stage-0 input taken from `rden`.
  - When a non-zero tag reaches the last stage, `rom_q` is sampled into the tagged slice of `data_out`.
  - On that same edge, the matching `ack` bit is set for exactly one cycle.
  - On that same edge, the `inflight` bit is cleared.
- Other slices hold their value; `data_out` is never cleared except by reset.
- Request hold rule:
  - An enemy holds `req` until it sees `ack`.
  - An `inflight` enemy is masked from arbitration from the grant edge through its ack edge.
  - If `req` is still high in the cycle after `ack`, it counts as a new request.
- `busy` = `|rden` OR any non-zero tag stage OR `|inflight`. Registered.
- Simultaneous ack and grant to the same enemy on one edge cannot occur, because the enemy is masked until its ack edge.
- Wrap-around: the search from `ptr+1` wraps from 7 to 0.
- Reset values, also applied when reset is asserted mid-operation:
  - `rden` = 0, `ack` = 0, `data_out` = 0, `busy` = 0.
  - All tags and `inflight` cleared; `ptr` = 7, so enemy 0 wins first.
  - Reads in flight at reset are dropped and produce no `ack`.

## Timing
- `req` sampled high at edge E0 with the enemy eligible and winning → `rden` bit high after E0 for one cycle.
- The mux registers the address at E1, and `rom_q` is valid after E(ROM_LAT).
- `data_out` slice and `ack` update at E(ROM_LAT+1). With the default ROM_LAT=2, `req`→`ack` latency is 3 edges.
- `ack` is high for exactly one cycle. `rden` is never high for the same enemy on two consecutive cycles.
- Reset is asynchronous. Outputs clear immediately on assertion; the first grant can occur at the first edge after deassertion.

## Test plan
- Single request: `req`=8'b0000_0100 from idle, with a ROM model returning 8'hA5.
  - `rden`=8'b0000_0100 for one cycle after E0.
  - `ack[2]` pulses after E3 and slice 2 = 8'hA5.
  - All other `data_out` slices = 0; `busy` falls after E3's cycle.
- All eight requesting at once (8'hFF), with the ROM returning 8'h10+i for a read granted to enemy i.
  - Grants go to enemies 0..7 on 8 consecutive cycles.
  - `ack[i]` pulses 3 edges after its grant, and slice i = 8'h10+i.
- Fairness: `req[3]` and `req[5]` held high permanently.
  - Grants alternate 3,5,3,5…
  - No enemy is granted again before its `ack`.
  - Neither is starved.
- Request held after ack: `req[0]` held high.
  - A re-grant of enemy 0 occurs the edge after `ack[0]`.
  - No second `rden[0]` appears while enemy 0 is in flight.
- Reset mid-flight: assert `reset` one cycle after `rden[6]`.
  - `rden`, `ack`, `data_out` and `busy` go to 0 immediately.
  - `ack[6]` never pulses for that read.
  - After deassertion with `req`=8'hFF, the first grant goes to enemy 0.
- ROM_LAT=3 build: single request to enemy 7.
  - `ack[7]` arrives 4 edges after the grant edge, with the data from the 3rd edge after `rden`.

Source files
------------

// File: rtl/enemy_rom_scheduler_if.sv
// Purpose : request/grant/return bundle between the enemy sprite engines, the address mux / ROM pair and the scheduler.
// Latency : wires only.
// Backpressure: none carried here; engines hold req until they see ack.
// Ports   : req (engines -> sched), rden (sched -> addr mux), rom_q (ROM -> sched),
//           data_out/ack (sched -> engines), busy (sched status).
interface enemy_rom_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [7:0]          req;
    logic [7:0]          rden;
    logic [DATA_W-1:0]   rom_q;
    logic [8*DATA_W-1:0] data_out;
    logic [7:0]          ack;
    logic                busy;

    // master: the scheduler itself
    modport master (
        input  req,
        input  rom_q,
        output rden,
        output data_out,
        output ack,
        output busy
    );

    // slave: the engines / ROM side
    modport slave (
        output req,
        output rom_q,
        input  rden,
        input  data_out,
        input  ack,
        input  busy
    );
endinterface

// File: rtl/enemy_rom_scheduler.sv
// Purpose : round-robin one-hot read grant for the shared enemy sprite ROM; returns each word to its requester with an ack pulse.
// Latency : req sampled at E0 -> rden after E0 -> data_out slice + ack after E(ROM_LAT+1).
// Backpressure: one grant per cycle; an enemy is masked from the grant edge through its ack edge.
// Ports   : clk, reset (async, active-high), bus (master modport: req, rom_q in; rden, data_out, ack, busy out).
module enemy_rom_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    enemy_rom_scheduler_if.master bus
);

    logic [2:0]          ptr_q;
    logic [7:0]          inflight_q;
    logic [7:0]          rden_q;
    logic [7:0]          ack_q;
    logic [8*DATA_W-1:0] data_q;
    logic                busy_q;

    // rden_q acts as tag stage 0; tag_q[ROM_LAT-1] is the stage whose
    // read data is on rom_q right now.
    logic [7:0]          tag_q [ROM_LAT];

    logic [7:0]          elig;
    logic                grant_vld;
    logic [2:0]          grant_idx;
    logic [2:0]          idx;
    logic [7:0]          grant_oh;
    logic [7:0]          ret_oh;
    logic [7:0]          inflight_nxt;
    logic                tag_any_nxt;
    logic                busy_nxt;

    always_comb begin
        elig      = bus.req & ~inflight_q;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        idx       = ptr_q;
        // Search upward from ptr+1; the 3-bit add wraps 7 -> 0, and the
        // final step (k=8) revisits ptr itself.
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        grant_oh = grant_vld ? (8'b1 << grant_idx) : 8'b0;

        ret_oh       = tag_q[ROM_LAT-1];
        inflight_nxt = (inflight_q & ~ret_oh) | grant_oh;

        // Tag stages as they will be after this edge: rden shifts into
        // stage 0, the last stage falls off.
        tag_any_nxt = |rden_q;
        for (int k = 0; k < ROM_LAT - 1; k++) begin
            tag_any_nxt = tag_any_nxt | (|tag_q[k]);
        end
        busy_nxt = (|grant_oh) | tag_any_nxt | (|inflight_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= 3'd7;
            inflight_q <= 8'h00;
            rden_q     <= 8'h00;
            ack_q      <= 8'h00;
            data_q     <= '0;
            busy_q     <= 1'b0;
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_q[k] <= 8'h00;
            end
        end else begin
            rden_q     <= grant_oh;
            inflight_q <= inflight_nxt;
            ack_q      <= ret_oh;
            busy_q     <= busy_nxt;
            if (grant_vld) begin
                ptr_q <= grant_idx;
            end
            tag_q[0] <= rden_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            for (int i = 0; i < 8; i++) begin
                if (ret_oh[i]) begin
                    data_q[i*DATA_W +: DATA_W] <= bus.rom_q;
                end
            end
        end
    end

    assign bus.rden     = rden_q;
    assign bus.ack      = ack_q;
    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_enemy_rom_scheduler.sv
module tb_enemy_rom_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    enemy_rom_scheduler_if #(.DATA_W(8)) b2 ();
    enemy_rom_scheduler_if #(.DATA_W(8)) b3 ();

    enemy_rom_scheduler #(.DATA_W(8), .ROM_LAT(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    enemy_rom_scheduler #(.DATA_W(8), .ROM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    // ROM model for the ROM_LAT=2 build: mux register, then registered ROM.
    logic [7:0] rom_tbl [8];
    logic [7:0] mux_q = 8'h00;
    logic [7:0] rom_sel = 8'h00;
    always @(posedge clk) begin
        mux_q   <= b2.rden;
        rom_sel <= mux_q;
    end
    always_comb begin
        b2.rom_q = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (rom_sel[i]) b2.rom_q = rom_tbl[i];
        end
    end

    // ROM_LAT=3 build: rom_q is an edge counter, so the captured word
    // tells exactly which edge's data was sampled.
    logic [7:0] cnt = 8'h00;
    always @(posedge clk) cnt <= cnt + 8'd1;
    assign b3.rom_q = cnt;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  e_rden;
        logic [7:0]  e_ack;
        logic [63:0] e_data;
        logic [7:0]  c0;

        b2.req = 8'h00;
        b3.req = 8'h00;
        for (int i = 0; i < 8; i++) rom_tbl[i] = 8'h00;
        #1;

        // Reset values
        chk("rst_rden", 64'(b2.rden), 64'h0);
        chk("rst_ack", 64'(b2.ack), 64'h0);
        chk("rst_data", b2.data_out, 64'h0);
        chk("rst_busy", 64'(b2.busy), 64'h0);
        chk("rst_busy3", 64'(b3.busy), 64'h0);
        tick();
        reset = 1'b0;

        // Single request to enemy 2
        rom_tbl[2] = 8'hA5;
        b2.req = 8'h04;
        tick(); // E0
        chk("s1_rden_e0", 64'(b2.rden), 64'h04);
        chk("s1_busy_e0", 64'(b2.busy), 64'h1);
        tick(); // E1
        chk("s1_rden_e1", 64'(b2.rden), 64'h00);
        chk("s1_ack_e1", 64'(b2.ack), 64'h00);
        tick(); // E2
        chk("s1_ack_e2", 64'(b2.ack), 64'h00);
        chk("s1_busy_e2", 64'(b2.busy), 64'h1);
        tick(); // E3
        chk("s1_ack_e3", 64'(b2.ack), 64'h04);
        chk("s1_rden_e3", 64'(b2.rden), 64'h00);
        chk("s1_data", b2.data_out, 64'h0000_0000_00A5_0000);
        b2.req = 8'h00;
        tick(); // E4
        chk("s1_ack_e4", 64'(b2.ack), 64'h00);
        chk("s1_busy_e4", 64'(b2.busy), 64'h0);

        // All eight at once
        do_reset();
        for (int i = 0; i < 8; i++) rom_tbl[i] = 8'h10 + 8'(i);
        b2.req = 8'hFF;
        for (int k = 0; k <= 10; k++) begin
            tick();
            e_rden = (k < 8) ? (8'b1 << k) : 8'h00;
            e_ack  = (k >= 3) ? (8'b1 << (k - 3)) : 8'h00;
            chk($sformatf("all_rden_%0d", k), 64'(b2.rden), 64'(e_rden));
            chk($sformatf("all_ack_%0d", k), 64'(b2.ack), 64'(e_ack));
            b2.req = b2.req & ~b2.ack;
        end
        for (int i = 0; i < 8; i++) e_data[i*8 +: 8] = 8'h10 + 8'(i);
        chk("all_data", b2.data_out, e_data);
        tick();
        chk("all_busy_end", 64'(b2.busy), 64'h0);

        // Fairness between enemies 3 and 5, both held high
        do_reset();
        b2.req = 8'h28;
        for (int k = 0; k < 12; k++) begin
            tick();
            case (k % 4)
                0:       e_rden = 8'h08;
                1:       e_rden = 8'h20;
                default: e_rden = 8'h00;
            endcase
            if (k % 4 == 3)            e_ack = 8'h08;
            else if (k % 4 == 0 && k > 0) e_ack = 8'h20;
            else                       e_ack = 8'h00;
            chk($sformatf("fair_rden_%0d", k), 64'(b2.rden), 64'(e_rden));
            chk($sformatf("fair_ack_%0d", k), 64'(b2.ack), 64'(e_ack));
        end
        b2.req = 8'h00;

        // Request held after ack: enemy 0
        do_reset();
        b2.req = 8'h01;
        for (int k = 0; k <= 4; k++) begin
            tick();
            e_rden = (k == 0 || k == 4) ? 8'h01 : 8'h00;
            e_ack  = (k == 3) ? 8'h01 : 8'h00;
            chk($sformatf("hold_rden_%0d", k), 64'(b2.rden), 64'(e_rden));
            chk($sformatf("hold_ack_%0d", k), 64'(b2.ack), 64'(e_ack));
        end

        // Reset mid-flight: enemy 6 granted, reset one cycle later
        b2.req = 8'h41;
        tick(); // E5
        chk("mid_rden6", 64'(b2.rden), 64'h40);
        chk("mid_data_pre", b2.data_out, 64'h10);
        tick(); // E6
        chk("mid_rden_e6", 64'(b2.rden), 64'h00);
        reset = 1'b1;
        #1;
        chk("mid_rst_rden", 64'(b2.rden), 64'h0);
        chk("mid_rst_ack", 64'(b2.ack), 64'h0);
        chk("mid_rst_data", b2.data_out, 64'h0);
        chk("mid_rst_busy", 64'(b2.busy), 64'h0);
        b2.req = 8'hFF;
        tick();
        chk("mid_inrst_ack_a", 64'(b2.ack), 64'h0);
        tick();
        chk("mid_inrst_ack_b", 64'(b2.ack), 64'h0);
        reset = 1'b0;
        tick();
        chk("mid_first_grant", 64'(b2.rden), 64'h01);
        chk("mid_post_ack0", 64'(b2.ack), 64'h0);
        tick();
        chk("mid_second_grant", 64'(b2.rden), 64'h02);
        chk("mid_post_ack1", 64'(b2.ack), 64'h0);
        tick();
        chk("mid_post_ack2", 64'(b2.ack), 64'h0);
        b2.req = 8'h00;

        // ROM_LAT=3 build, enemy 7
        do_reset();
        b3.req = 8'h80;
        tick(); // E0
        chk("l3_rden", 64'(b3.rden), 64'h80);
        c0 = cnt;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("l3_ack_e%0d", k), 64'(b3.ack), 64'h00);
            chk($sformatf("l3_rden_e%0d", k), 64'(b3.rden), 64'h00);
        end
        tick(); // E4
        chk("l3_ack_e4", 64'(b3.ack), 64'h80);
        chk("l3_data7", 64'(b3.data_out[63:56]), 64'(8'(c0 + 8'd3)));
        chk("l3_data_low", 64'(b3.data_out[55:0]), 64'h0);
        b3.req = 8'h00;
        tick();
        chk("l3_ack_e5", 64'(b3.ack), 64'h00);
        chk("l3_busy_e5", 64'(b3.busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
